// File: rtl/qspi_xip_ctrl.sv
// qspi_xip_ctrl: read-only AHB-Lite XIP bridge to a quad-SPI NOR flash.
// Direct-mapped line cache, refilled with EBh quad-I/O reads on a miss.
module qspi_xip_ctrl #(
  parameter int LINE_SIZE = 16,
  parameter int NUM_LINES = 32
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HADDR,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  input  logic [3:0]  din,
  output logic [3:0]  dout,
  output logic        douten,
  output logic        sck,
  output logic        ce_n
);
  localparam int OW  = $clog2(LINE_SIZE);
  localparam int IW  = $clog2(NUM_LINES);
  localparam int TW  = 24 - OW - IW;
  localparam int WPL = LINE_SIZE / 4;
  localparam int WW  = (OW > 2) ? OW - 2 : 1;
  localparam int CW  = OW + 1;
  localparam int NIB = 2 * LINE_SIZE;
  localparam logic [7:0] CMD_EB = 8'hEB;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, MODE, DUMMY, DATA, DONE
  } state_t;

  state_t        state, state_n, nxt;
  logic [CW-1:0] cnt, cnt_n, plast;
  logic          sck_n, ce_n_n, douten_n, xfer;
  logic [3:0]    dout_n;
  logic [23:0]   sh;

  logic          rd_req;
  logic [23:0]   raddr;
  logic [OW-1:0] roff;
  logic [IW-1:0] ridx;
  logic [TW-1:0] rtag;
  logic [WW-1:0] rword;
  logic [23:0]   line_addr;
  logic          hit, fill_end;

  logic [NUM_LINES-1:0] valid;
  logic [TW-1:0]        tags [NUM_LINES];
  logic [31:0]          mem  [NUM_LINES][WPL];
  logic [3:0]           hi;
  logic [OW-1:0]        bidx;
  logic [WW-1:0]        bword;
  logic [1:0]           blane;

  logic unused_ok;
  assign unused_ok = ^{HADDR[31:24], HTRANS[0]};

  assign {rtag, ridx, roff} = raddr;
  assign rword     = WW'(roff >> 2);
  assign line_addr = {raddr[23:OW], {OW{1'b0}}};
  assign hit       = rd_req && valid[ridx] && (tags[ridx] == rtag);
  assign fill_end  = (state == DATA) && sck && (cnt == plast);
  assign bidx      = cnt[CW-1:1];
  assign bword     = WW'(bidx >> 2);
  assign blane     = bidx[1:0];

  // address phase: latch read requests while the bus is ready
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rd_req <= 1'b0;
      raddr  <= '0;
    end else if (HREADY) begin
      rd_req <= HSEL && HTRANS[1] && !HWRITE;
      raddr  <= HADDR[23:0];
    end
  end

  // length and successor of each serial phase
  always_comb begin
    plast = '0;
    nxt   = IDLE;
    unique case (state)
      CMD:     begin plast = CW'(7);     nxt = ADDR;  end
      ADDR:    begin plast = CW'(5);     nxt = MODE;  end
      MODE:    begin plast = CW'(1);     nxt = DUMMY; end
      DUMMY:   begin plast = CW'(3);     nxt = DATA;  end
      DATA:    begin plast = CW'(NIB-1); nxt = DONE;  end
      default: ;
    endcase
  end

  // next state, phase counter and next pin values
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (state == IDLE) begin
      if (rd_req && !hit) begin
        state_n = CMD;
        cnt_n   = '0;
      end
    end else if (state == DONE) begin
      state_n = IDLE;
    end else if (sck) begin
      if (cnt == plast) begin
        state_n = nxt;
        cnt_n   = '0;
      end else begin
        cnt_n = cnt + CW'(1);
      end
    end
    xfer     = state_n inside {CMD, ADDR, MODE, DUMMY, DATA};
    sck_n    = xfer && (state != IDLE) && !sck;
    ce_n_n   = !xfer;
    douten_n = state_n inside {CMD, ADDR, MODE};
    sh       = line_addr << {cnt_n[2:0], 2'b00};
    dout_n   = '0;
    unique case (state_n)
      CMD:     dout_n = {3'b111, CMD_EB[3'd7 - cnt_n[2:0]]};
      ADDR:    dout_n = sh[23:20];
      MODE:    dout_n = 4'hF;
      default: ;
    endcase
  end

  // FSM and registered flash pins
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state  <= IDLE;
      cnt    <= '0;
      sck    <= 1'b0;
      ce_n   <= 1'b1;
      douten <= 1'b0;
      dout   <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      sck    <= sck_n;
      ce_n   <= ce_n_n;
      douten <= douten_n;
      dout   <= dout_n;
    end
  end

  // line valid bits: dropped when a refill starts, set when it ends
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      valid <= '0;
    end else if (state == IDLE && rd_req && !hit) begin
      valid[ridx] <= 1'b0;
    end else if (fill_end) begin
      valid[ridx] <= 1'b1;
    end
  end

  // cache storage: assemble bytes from nibbles, little-endian in words
  always_ff @(posedge HCLK) begin
    if (state == DATA && sck) begin
      if (!cnt[0]) begin
        hi <= din;
      end else begin
        mem[ridx][bword][{blane, 3'b000} +: 8] <= {hi, din};
      end
      if (fill_end) begin
        tags[ridx] <= rtag;
      end
    end
  end

  // data-phase response
  always_comb begin
    HRDATA    = '0;
    HREADYOUT = 1'b1;
    unique case (1'b1)
      (state == DONE): HRDATA = mem[ridx][rword];
      (state == IDLE): begin
        if (hit) begin
          HRDATA = mem[ridx][rword];
        end else if (rd_req) begin
          HREADYOUT = 1'b0;
        end
      end
      default: HREADYOUT = 1'b0;
    endcase
  end
endmodule

// File: tb/tb_qspi_xip_ctrl.sv
// tb_qspi_xip_ctrl: random AHB reads against a flash pin model,
// scoreboard of expected words, wait counts and refill counts.
module tb_qspi_xip_ctrl;
  localparam int LS        = 16;
  localparam int NL        = 32;
  localparam int MISS_WAIT = 2 * (20 + 2 * LS) + 1;

  typedef struct {
    logic [31:0] data;
    int          waits;
    int          fills;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hsel = 1'b0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [31:0] haddr = '0;
  logic        hready;
  logic        hreadyout;
  logic [31:0] hrdata;
  logic [3:0]  din = 4'h0;
  logic [3:0]  dout;
  logic        douten, sck, ce_n;

  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        sb[$];
  logic [23:0] exp_addr[$];
  int          mtag[int];
  logic [7:0]  boot [16];

  always #5 clk = ~clk;
  assign hready = hreadyout;

  qspi_xip_ctrl #(.LINE_SIZE(LS), .NUM_LINES(NL)) dut (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(hsel), .HREADY(hready),
    .HTRANS(htrans), .HWRITE(hwrite), .HADDR(haddr),
    .HREADYOUT(hreadyout), .HRDATA(hrdata),
    .din(din), .dout(dout), .douten(douten), .sck(sck), .ce_n(ce_n)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] fbyte(input logic [23:0] a);
    if (a < 24'd16) return boot[a[3:0]];
    return (a[7:0] * 8'd37) ^ a[15:8] ^ {a[19:16], a[23:20]} ^ 8'h5a;
  endfunction

  function automatic logic [31:0] fword(input logic [23:0] a);
    logic [23:0] w;
    w = {a[23:2], 2'b00};
    return {fbyte(w + 24'd3), fbyte(w + 24'd2),
            fbyte(w + 24'd1), fbyte(w)};
  endfunction

  // reference cache: line number split into index and tag
  task automatic model_push(input logic [23:0] a);
    exp_t e;
    int line, idx, tag;
    line = int'(a) / LS;
    idx  = line % NL;
    tag  = line / NL;
    e.data = fword(a);
    if (mtag.exists(idx) && mtag[idx] == tag) begin
      e.waits = 0;
      e.fills = 0;
    end else begin
      e.waits = MISS_WAIT;
      e.fills = 1;
      exp_addr.push_back(24'(line * LS));
    end
    mtag[idx] = tag;
    sb.push_back(e);
  endtask

  task automatic xfer(input logic s, input logic [1:0] t,
                      input logic w, input logic [31:0] a);
    int k;
    hsel = s; htrans = t; hwrite = w; haddr = a;
    k = 0;
    @(negedge clk);
    while (!hready && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2000) chk("hready_timeout", 32'd0, 32'd1);
    if (s && t[1] && !w) model_push(a[23:0]);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = '0;
  endtask

  task automatic chk_reset_pins();
    chk("rst_ce_n", 32'(ce_n), 32'd1);
    chk("rst_sck", 32'(sck), 32'd0);
    chk("rst_douten", 32'(douten), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_hreadyout", 32'(hreadyout), 32'd1);
  endtask

  // flash pin model: decodes the EBh sequence and serves the image
  int          fn = 0;
  bit          fl_on = 1'b0;
  bit          aborting = 1'b0;
  bit          bad = 1'b0;
  logic [7:0]  fcmd, fmode;
  logic [23:0] faddr;

  always @(negedge ce_n) begin
    fn = 0; fl_on = 1'b1; bad = 1'b0;
    fcmd = '0; fmode = '0; faddr = '0; din = 4'h0;
  end

  always @(posedge sck) begin
    if (fl_on && !ce_n) begin
      if (fn < 8) begin
        fcmd = {fcmd[6:0], dout[0]};
        if (dout[3:1] != 3'b111 || !douten) bad = 1'b1;
      end else if (fn < 14) begin
        faddr = {faddr[19:0], dout};
        if (!douten) bad = 1'b1;
      end else if (fn < 16) begin
        fmode = {fmode[3:0], dout};
        if (!douten) bad = 1'b1;
      end else if (douten) begin
        bad = 1'b1;
      end
      if (fn == 7) chk("cmd", 32'(fcmd), 32'h0000_00eb);
      if (fn == 13) begin
        if (exp_addr.size() == 0) chk("addr_unexpected", 32'd1, 32'd0);
        else chk("addr", 32'(faddr), 32'(exp_addr.pop_front()));
      end
      if (fn == 15) chk("mode", 32'(fmode), 32'h0000_00ff);
      if (fn >= 20 && fn < 20 + 2 * LS) begin
        logic [7:0] b;
        b = fbyte(faddr + 24'((fn - 20) / 2));
        din = ((fn - 20) % 2 == 0) ? b[7:4] : b[3:0];
      end
      fn++;
    end
  end

  always @(posedge ce_n) begin
    if (fl_on) begin
      fl_on = 1'b0;
      if (!aborting) begin
        chk("sck_count", 32'(fn), 32'(20 + 2 * LS));
        chk("pin_dir", 32'(bad), 32'd0);
      end
    end
  end

  // bus monitor: pops the scoreboard whenever a read data phase ends
  logic dp_rd = 1'b0;
  logic dp_oth = 1'b0;
  int   waits = 0;
  int   ce_falls = 0;
  exp_t mon_e;

  always @(negedge ce_n) ce_falls++;

  always @(negedge clk) begin
    if (!rst_n) begin
      dp_rd = 1'b0; dp_oth = 1'b0; waits = 0; ce_falls = 0;
    end else begin
      if (dp_rd) begin
        if (!hreadyout) begin
          waits++;
        end else if (sb.size() == 0) begin
          chk("read_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("rdata", hrdata, mon_e.data);
          chk("waits", 32'(waits), 32'(mon_e.waits));
          chk("refills", 32'(ce_falls), 32'(mon_e.fills));
          waits = 0;
          ce_falls = 0;
        end
      end else if (dp_oth) begin
        chk("idle_ready", 32'(hreadyout), 32'd1);
        chk("idle_rdata", hrdata, 32'd0);
      end
      if (hreadyout) begin
        dp_rd  = hsel && htrans[1] && !hwrite;
        dp_oth = !dp_rd;
      end
    end
  end

  initial begin
    int k, r;
    logic [31:0] a;
    boot = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00,
             8'hb7, 8'h02, 8'h00, 8'h10, 8'h6f, 8'h00, 8'h00, 8'h00};
    #12;
    chk_reset_pins();
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // cold fill, then sequential hits in the same line
    xfer(1'b1, 2'b10, 1'b0, 32'h0000_0000);
    xfer(1'b1, 2'b10, 1'b0, 32'h0000_0004);
    xfer(1'b1, 2'b10, 1'b0, 32'h0000_0008);
    xfer(1'b1, 2'b10, 1'b0, 32'h0000_000C);
    // conflict on index 0
    xfer(1'b1, 2'b10, 1'b0, 32'h0000_0200);
    xfer(1'b1, 2'b10, 1'b0, 32'h0000_0000);
    // writes, unselected and idle transfers leave the cache alone
    xfer(1'b1, 2'b10, 1'b1, 32'h0000_0010);
    xfer(1'b0, 2'b10, 1'b0, 32'h0000_0040);
    xfer(1'b1, 2'b00, 1'b0, 32'h0000_0080);
    xfer(1'b1, 2'b10, 1'b0, 32'h0000_0004);

    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 7);
      a = ($urandom & 32'hff00_0000)
        | (32'($urandom_range(0, 1)) << 20)
        | (32'($urandom_range(0, 3)) << 9)
        | (32'($urandom_range(0, 3)) << 4)
        | 32'($urandom_range(0, 15));
      if (r == 0) xfer(1'b1, 2'b10, 1'b1, a);
      else if (r == 1) xfer(1'b0, 2'b00, 1'b0, 32'h0);
      else xfer(1'b1, 2'b10, 1'b0, a);
    end

    // reset in the middle of the data phase of a refill
    xfer(1'b1, 2'b10, 1'b0, 32'h0000_1230);
    idle();
    k = 0;
    while (!(fl_on && fn >= 30) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("reach_data", 32'(fl_on && fn >= 30), 32'd1);
    aborting = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_pins();
    sb.delete();
    exp_addr.delete();
    mtag.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    aborting = 1'b0;
    @(posedge clk);
    #1;
    xfer(1'b1, 2'b10, 1'b0, 32'h0000_1230);
    xfer(1'b1, 2'b10, 1'b0, 32'h0000_1234);
    idle();

    k = 0;
    while (sb.size() > 0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
